// File: rtl/aes_decrypt_concat.sv
// AES-256 decryption core: one beat in (key + ciphertext), one beat out (plaintext).
// Iterative, one round per cycle, with the key schedule expanded into a register file first.
module aes_decrypt_concat (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s0_tvalid_i,
    input  logic [511:0] s0_tdata_i,
    output logic         s0_tready_o,
    output logic         s_out_tvalid_o,
    output logic [511:0] s_out_tdata_o,
    input  logic         s_out_tready_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] KEYEXP = 2'd1;
    localparam logic [1:0] DEC    = 2'd2;
    localparam logic [1:0] OUT    = 2'd3;

    // Entry 0 sits in the top byte, so entry x lives at bit offset 8*(255-x).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return INV_SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        logic [31:0] o;
        for (int k = 0; k < 4; k++) o[8*k +: 8] = sbox(w[8*k +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = invSbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte r+4c is row r, column c; row r rotates right by r columns.
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+4-r)%4)) +: 8];
        return o;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = '0;
        pw  = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) acc ^= pw;
            pw = {pw[6:0], 1'b0} ^ (pw[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[32*c + 8  +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[32*c + 16 +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[32*c + 24 +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   roundCnt_q, roundCnt_d;
    logic [127:0] blockState_q, blockState_d;
    logic [127:0] plain_q, plain_d;
    logic         inReady_q;
    logic         outValid_q;
    logic [127:0] rk_q [15];

    logic         accept;
    logic         unusedTdata;
    logic [3:0]   prevIdx1, prevIdx2;
    logic [7:0]   rcon;
    logic [31:0]  schedTemp;
    logic [127:0] prevKey2, newKey;
    logic [127:0] roundKey, keyed, mixed;

    assign accept      = s0_tvalid_i && inReady_q;
    assign unusedTdata = ^s0_tdata_i[511:384];
    assign prevIdx1    = roundCnt_q - 4'd1;
    assign prevIdx2    = roundCnt_q - 4'd2;
    assign rcon        = 8'h01 << (roundCnt_q[3:1] - 3'd1);

    // The counter names the round key being produced: even keys start with
    // RotWord/SubWord/Rcon, odd keys with SubWord alone.
    always_comb begin
        prevKey2  = rk_q[prevIdx2];
        schedTemp = rk_q[prevIdx1][127:96];
        if (!roundCnt_q[0])
            schedTemp = subWord({schedTemp[7:0], schedTemp[31:8]}) ^ {24'h0, rcon};
        else
            schedTemp = subWord(schedTemp);
        newKey[31:0]   = prevKey2[31:0]   ^ schedTemp;
        newKey[63:32]  = prevKey2[63:32]  ^ newKey[31:0];
        newKey[95:64]  = prevKey2[95:64]  ^ newKey[63:32];
        newKey[127:96] = prevKey2[127:96] ^ newKey[95:64];
    end

    always_comb begin
        roundKey = rk_q[roundCnt_q];
        keyed    = invSubBytes(invShiftRows(blockState_q)) ^ roundKey;
        mixed    = invMixColumns(keyed);
    end

    always_comb begin
        fsm_d        = fsm_q;
        roundCnt_d   = roundCnt_q;
        blockState_d = blockState_q;
        plain_d      = plain_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    fsm_d        = KEYEXP;
                    roundCnt_d   = 4'd2;
                    blockState_d = s0_tdata_i[383:256];
                end
            end
            KEYEXP: begin
                if (roundCnt_q == 4'd14) fsm_d = DEC;
                else roundCnt_d = roundCnt_q + 4'd1;
            end
            DEC: begin
                if (roundCnt_q == 4'd14) begin
                    blockState_d = blockState_q ^ roundKey;
                    roundCnt_d   = 4'd13;
                end else if (roundCnt_q == 4'd0) begin
                    blockState_d = keyed;
                    plain_d      = keyed;
                    fsm_d        = OUT;
                end else begin
                    blockState_d = mixed;
                    roundCnt_d   = roundCnt_q - 4'd1;
                end
            end
            default: begin
                if (s_out_tready_i) fsm_d = IDLE;
            end
        endcase
    end

    // Handshake flags are registered straight from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            roundCnt_q   <= '0;
            blockState_q <= '0;
            plain_q      <= '0;
            inReady_q    <= 1'b0;
            outValid_q   <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            roundCnt_q   <= roundCnt_d;
            blockState_q <= blockState_d;
            plain_q      <= plain_d;
            inReady_q    <= (fsm_d == IDLE);
            outValid_q   <= (fsm_d == OUT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rk_q[i] <= '0;
        end else if (accept) begin
            rk_q[0] <= s0_tdata_i[127:0];
            rk_q[1] <= s0_tdata_i[255:128];
        end else if (fsm_q == KEYEXP) begin
            rk_q[roundCnt_q] <= newKey;
        end
    end

    assign s0_tready_o    = inReady_q;
    assign s_out_tvalid_o = outValid_q;
    assign s_out_tdata_o  = {384'b0, plain_q};

endmodule

// File: tb/tb_aes_decrypt_concat.sv
// Self-checking bench for aes_decrypt_concat: known answers plus random blocks
// compared against a textbook AES-256 inverse cipher built from GF(2^8) arithmetic.
module tb_aes_decrypt_concat;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s0Tvalid = 1'b0;
    logic [511:0] s0Tdata = '0;
    logic         s0Tready;
    logic         sOutTvalid;
    logic [511:0] sOutTdata;
    logic         sOutTready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwdBox [256];
    logic [7:0] invBox [256];

    always #5 clk = ~clk;

    aes_decrypt_concat dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s0_tvalid_i    (s0Tvalid),
        .s0_tdata_i     (s0Tdata),
        .s0_tready_o    (s0Tready),
        .s_out_tvalid_o (sOutTvalid),
        .s_out_tdata_o  (sOutTdata),
        .s_out_tready_i (sOutTready)
    );

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic buildBoxes();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fwdBox[x] = s;
            invBox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subWordModel(input logic [31:0] w);
        return {fwdBox[w[31:24]], fwdBox[w[23:16]], fwdBox[w[15:8]], fwdBox[w[7:0]]};
    endfunction

    // Byte-reverse so vectors can be written in FIPS reading order (byte 0 leftmost).
    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = v[8*(31-k) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] rev128(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
        return r;
    endfunction

    // FIPS-197 InvCipher with words held big-endian (first byte in the top bits).
    function automatic logic [127:0] modelDecrypt(input logic [255:0] key, input logic [127:0] ct);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 8; i++)
            w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subWordModel({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gfMul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subWordModel(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = ct[8*k +: 8] ^ w[56 + k/4][8*(3 - k%4) +: 8];
        for (int rnd = 13; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r + 4*((c + r) % 4)] = s[r + 4*c];
            for (int k = 0; k < 16; k++) s[k] = invBox[t[k]] ^ w[4*rnd + k/4][8*(3 - k%4) +: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
                    s[4*c+1] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
                    s[4*c+2] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
                    s[4*c+3] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
                end
            end
        end
        for (int k = 0; k < 16; k++) res[8*k +: 8] = s[k];
        return res;
    endfunction

    // Holds tvalid until the beat is taken; returns one step past the accepting edge.
    task automatic applyStimulus(input logic [255:0] key, input logic [127:0] ct,
                                 output int waited, output bit ok);
        ok = 1'b0;
        waited = 0;
        s0Tdata = {$urandom(), $urandom(), $urandom(), $urandom(), ct, key};
        s0Tvalid = 1'b1;
        while (!ok && waited < 100) begin
            if (s0Tready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
                waited++;
            end
        end
        s0Tvalid = 1'b0;
    endtask

    task automatic waitOutput(output int latency, output bit ok);
        ok = 1'b0;
        latency = 0;
        while (!ok && latency < 60) begin
            @(posedge clk); #1;
            latency++;
            if (sOutTvalid) ok = 1'b1;
        end
    endtask

    task automatic takeOutput();
        sOutTready = 1'b1;
        @(posedge clk); #1;
        sOutTready = 1'b0;
    endtask

    task automatic runBlock(input logic [255:0] key, input logic [127:0] ct,
                            output int latency, output bit ok);
        int waited;
        bit okIn;
        bit okOut;
        applyStimulus(key, ct, waited, okIn);
        okOut = 1'b0;
        latency = 0;
        if (okIn) waitOutput(latency, okOut);
        ok = okIn && okOut;
    endtask

    task automatic test_reset();
        s0Tvalid = 1'b0;
        sOutTready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s0Tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready got %b expected 0", s0Tready); end
        checks++;
        if (sOutTvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b expected 0", sOutTvalid); end
        checks++;
        if (sOutTdata !== 512'b0) begin errors++; $display("[TB] FAIL reset_tdata got %h expected 0", sOutTdata); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s0Tready !== 1'b0) begin errors++; $display("[TB] FAIL tready_before_edge got %b expected 0", s0Tready); end
        @(posedge clk); #1;
        checks++;
        if (s0Tready !== 1'b1) begin errors++; $display("[TB] FAIL tready_after_edge got %b expected 1", s0Tready); end
    endtask

    task automatic test_fips_c3();
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] expPt;
        int waited;
        int latency;
        bit ok;
        key   = rev256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        ct    = rev128(128'h8ea2b7ca516745bfeafc49904b496089);
        expPt = rev128(128'h00112233445566778899aabbccddeeff);
        applyStimulus(key, ct, waited, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL c3_accept got timeout expected acceptance"); end
        checks++;
        if (s0Tready !== 1'b0) begin errors++; $display("[TB] FAIL c3_busy_tready got %b expected 0", s0Tready); end
        waitOutput(latency, ok);
        checks++;
        if (!ok || latency != 28) begin errors++; $display("[TB] FAIL c3_latency got %0d expected 28", latency); end
        checks++;
        if (sOutTdata !== {384'b0, expPt}) begin errors++; $display("[TB] FAIL c3_data got %h expected %h", sOutTdata, {384'b0, expPt}); end
        checks++;
        if (s0Tready !== 1'b0) begin errors++; $display("[TB] FAIL c3_out_tready got %b expected 0", s0Tready); end
        takeOutput();
        checks++;
        if (sOutTvalid !== 1'b0) begin errors++; $display("[TB] FAIL c3_tvalid_drop got %b expected 0", sOutTvalid); end
        checks++;
        if (s0Tready !== 1'b1) begin errors++; $display("[TB] FAIL c3_tready_back got %b expected 1", s0Tready); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] key;
        logic [127:0] ct [2];
        logic [127:0] expPt;
        int waited;
        int latency;
        bit ok;
        key   = rev256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        ct[0] = rev128(128'he0a8f50ec76a04d5a96a175aa870ef63);
        ct[1] = rev128(128'h542ddea4d5faad623ef884cf4e198bdc);
        for (int b = 0; b < 2; b++) begin
            expPt = modelDecrypt(key, ct[b]);
            applyStimulus(key, ct[b], waited, ok);
            checks++;
            if (!ok || waited != 0) begin errors++; $display("[TB] FAIL b2b_accept_%0d got wait %0d expected 0", b, waited); end
            waitOutput(latency, ok);
            checks++;
            if (!ok || latency != 28) begin errors++; $display("[TB] FAIL b2b_latency_%0d got %0d expected 28", b, latency); end
            checks++;
            if (sOutTdata !== {384'b0, expPt}) begin errors++; $display("[TB] FAIL b2b_data_%0d got %h expected %h", b, sOutTdata, {384'b0, expPt}); end
            takeOutput();
        end
    endtask

    task automatic test_known_keys();
        logic [255:0] key [2];
        logic [127:0] ct [2];
        logic [127:0] expPt;
        int latency;
        bit ok;
        key[0] = {256{1'b1}};
        ct[0]  = rev128(128'h4bf85f1b5d54adbc307b0a048389adcb);
        key[1] = '0;
        ct[1]  = rev128(128'hacdace8078a32b1a182bfa4987ca1347);
        for (int b = 0; b < 2; b++) begin
            expPt = modelDecrypt(key[b], ct[b]);
            runBlock(key[b], ct[b], latency, ok);
            checks++;
            if (!ok || sOutTdata !== {384'b0, expPt}) begin
                errors++;
                $display("[TB] FAIL keys_data_%0d got %h expected %h", b, sOutTdata, {384'b0, expPt});
            end
            takeOutput();
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] expPt;
        int latency;
        bit ok;
        bit sawValid;
        key   = rev256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        ct    = {$urandom(), $urandom(), $urandom(), $urandom()};
        expPt = modelDecrypt(key, ct);
        runBlock(key, ct, latency, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL bp_output got timeout expected tvalid"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (sOutTvalid !== 1'b1 || sOutTdata !== {384'b0, expPt}) begin
                errors++;
                $display("[TB] FAIL bp_hold_%0d got %b/%h expected 1/%h", i, sOutTvalid, sOutTdata, {384'b0, expPt});
            end
            if (i == 3) begin
                s0Tvalid = 1'b1;
                s0Tdata  = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
                checks++;
                if (s0Tready !== 1'b0) begin errors++; $display("[TB] FAIL bp_tready got %b expected 0", s0Tready); end
            end
            @(posedge clk); #1;
            s0Tvalid = 1'b0;
        end
        takeOutput();
        checks++;
        if (sOutTvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_single_beat got %b expected 0", sOutTvalid); end
        sawValid = 1'b0;
        sOutTready = 1'b1;
        repeat (35) begin
            @(posedge clk); #1;
            if (sOutTvalid) sawValid = 1'b1;
        end
        sOutTready = 1'b0;
        checks++;
        if (sawValid) begin errors++; $display("[TB] FAIL bp_extra_beat got tvalid 1 expected 0"); end
        checks++;
        if (sOutTdata !== {384'b0, expPt}) begin errors++; $display("[TB] FAIL bp_data_kept got %h expected %h", sOutTdata, {384'b0, expPt}); end
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] expPt;
        int latency;
        bit ok;
        for (int n = 0; n < 8; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            ct  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expPt = modelDecrypt(key, ct);
            runBlock(key, ct, latency, ok);
            checks++;
            if (!ok || latency != 28) begin errors++; $display("[TB] FAIL rand_latency_%0d got %0d expected 28", n, latency); end
            checks++;
            if (sOutTdata !== {384'b0, expPt}) begin errors++; $display("[TB] FAIL rand_data_%0d got %h expected %h", n, sOutTdata, {384'b0, expPt}); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            takeOutput();
        end
    endtask

    task automatic test_reset_abort();
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] expPt;
        int waited;
        int latency;
        bit ok;
        bit sawValid;
        key   = rev256(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        ct    = rev128(128'h8ea2b7ca516745bfeafc49904b496089);
        expPt = rev128(128'h00112233445566778899aabbccddeeff);
        applyStimulus(key, ct, waited, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL abort_accept got timeout expected acceptance"); end
        repeat (17) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (s0Tready !== 1'b0 || sOutTvalid !== 1'b0 || sOutTdata !== 512'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs got %b/%b/%h expected 0/0/0", s0Tready, sOutTvalid, sOutTdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (sOutTvalid) sawValid = 1'b1;
        end
        checks++;
        if (sawValid) begin errors++; $display("[TB] FAIL abort_no_beat got tvalid 1 expected 0"); end
        runBlock(key, ct, latency, ok);
        checks++;
        if (!ok || latency != 28 || sOutTdata !== {384'b0, expPt}) begin
            errors++;
            $display("[TB] FAIL abort_recover got %0d/%h expected 28/%h", latency, sOutTdata, {384'b0, expPt});
        end
        takeOutput();
    endtask

    initial begin
        buildBoxes();
        test_reset();
        test_fips_c3();
        test_back_to_back();
        test_known_keys();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
